// File: rtl/nvdla_glb_intr_ctrl.sv
// NVDLA global interrupt controller: collects per-engine done pulses into sticky
// status bits (software set / W1C), gated by masks into a registered core_intr.
// Optional macro NVDLA_GLB_INTR_OVERFLOW_EN adds sticky per-source overflow flags.
module nvdla_glb_intr_ctrl (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,

    input  logic [1:0]  sdp2glb_done_intr_pd,
    input  logic [1:0]  cdp2glb_done_intr_pd,
    input  logic [1:0]  pdp2glb_done_intr_pd,
    input  logic [1:0]  cdma_dat2glb_done_intr_pd,
    input  logic [1:0]  cdma_wt2glb_done_intr_pd,
    input  logic [1:0]  cacc2glb_done_intr_pd,

    input  logic        sdp_done_mask0,
    input  logic        sdp_done_mask1,
    input  logic        cdp_done_mask0,
    input  logic        cdp_done_mask1,
    input  logic        pdp_done_mask0,
    input  logic        pdp_done_mask1,
    input  logic        cdma_dat_done_mask0,
    input  logic        cdma_dat_done_mask1,
    input  logic        cdma_wt_done_mask0,
    input  logic        cdma_wt_done_mask1,
    input  logic        cacc_done_mask0,
    input  logic        cacc_done_mask1,

    input  logic        sdp_done_set0_trigger,
    input  logic        sdp_done_status0_trigger,
    input  logic [31:0] reg_wr_data,

    output logic        sdp_done_status0,
    output logic        sdp_done_status1,
    output logic        cdp_done_status0,
    output logic        cdp_done_status1,
    output logic        pdp_done_status0,
    output logic        pdp_done_status1,
    output logic        cdma_dat_done_status0,
    output logic        cdma_dat_done_status1,
    output logic        cdma_wt_done_status0,
    output logic        cdma_wt_done_status1,
    output logic        cacc_done_status0,
    output logic        cacc_done_status1,

    output logic        sdp_done_set0,
    output logic        sdp_done_set1,
    output logic        cdp_done_set0,
    output logic        cdp_done_set1,
    output logic        pdp_done_set0,
    output logic        pdp_done_set1,
    output logic        cdma_dat_done_set0,
    output logic        cdma_dat_done_set1,
    output logic        cdma_wt_done_set0,
    output logic        cdma_wt_done_set1,
    output logic        cacc_done_set0,
    output logic        cacc_done_set1,

    output logic        core_intr
`ifdef NVDLA_GLB_INTR_OVERFLOW_EN
    ,
    output logic [11:0] intr_overflow
`endif
);

    localparam int NUM_SRC = 12;

    logic [NUM_SRC-1:0] done_pulse;
    logic [NUM_SRC-1:0] done_mask;
    logic [NUM_SRC-1:0] wr_map;
    logic [NUM_SRC-1:0] sw_set;
    logic [NUM_SRC-1:0] w1c_clr;
    logic [NUM_SRC-1:0] status_reg;
    logic [NUM_SRC-1:0] status_next;
    logic [NUM_SRC-1:0] pending;
    logic               core_intr_reg;
    logic               core_intr_next;

    // Source index k: sdp0/1, cdp0/1, pdp0/1, cdma_dat0/1, cdma_wt0/1, cacc0/1.
    assign done_pulse = {cacc2glb_done_intr_pd, cdma_wt2glb_done_intr_pd,
                         cdma_dat2glb_done_intr_pd, pdp2glb_done_intr_pd,
                         cdp2glb_done_intr_pd, sdp2glb_done_intr_pd};

    assign done_mask = {cacc_done_mask1, cacc_done_mask0,
                        cdma_wt_done_mask1, cdma_wt_done_mask0,
                        cdma_dat_done_mask1, cdma_dat_done_mask0,
                        pdp_done_mask1, pdp_done_mask0,
                        cdp_done_mask1, cdp_done_mask0,
                        sdp_done_mask1, sdp_done_mask0};

    // Register layout packs the convolution-side sources at bits 16..21.
    assign wr_map = {reg_wr_data[21:16], reg_wr_data[5:0]};

    logic unused_wr_bits;
    assign unused_wr_bits = ^{reg_wr_data[31:22], reg_wr_data[15:6]};

    assign sw_set  = sdp_done_set0_trigger    ? wr_map : '0;
    assign w1c_clr = sdp_done_status0_trigger ? wr_map : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            // Sets take priority over a coincident clear so no event is dropped.
            assign status_next[gi] = done_pulse[gi] | sw_set[gi] |
                                     (status_reg[gi] & ~w1c_clr[gi]);
            assign pending[gi]     = status_reg[gi] & ~done_mask[gi];
        end
    endgenerate

    assign core_intr_next = |pending;

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            status_reg    <= '0;
            core_intr_reg <= 1'b0;
        end else begin
            status_reg    <= status_next;
            core_intr_reg <= core_intr_next;
        end
    end

`ifdef NVDLA_GLB_INTR_OVERFLOW_EN
    logic [NUM_SRC-1:0] overflow_reg;
    logic [NUM_SRC-1:0] overflow_next;

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_ovf
            // Only hardware pulses landing on an uncleared, already-set bit count as lost.
            assign overflow_next[gi] = (overflow_reg[gi] & ~w1c_clr[gi]) |
                                       (done_pulse[gi] & status_reg[gi] & ~w1c_clr[gi]);
        end
    endgenerate

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            overflow_reg <= '0;
        end else begin
            overflow_reg <= overflow_next;
        end
    end

    assign intr_overflow = overflow_reg;
`endif

    assign core_intr = core_intr_reg;

    assign sdp_done_status0      = status_reg[0];
    assign sdp_done_status1      = status_reg[1];
    assign cdp_done_status0      = status_reg[2];
    assign cdp_done_status1      = status_reg[3];
    assign pdp_done_status0      = status_reg[4];
    assign pdp_done_status1      = status_reg[5];
    assign cdma_dat_done_status0 = status_reg[6];
    assign cdma_dat_done_status1 = status_reg[7];
    assign cdma_wt_done_status0  = status_reg[8];
    assign cdma_wt_done_status1  = status_reg[9];
    assign cacc_done_status0     = status_reg[10];
    assign cacc_done_status1     = status_reg[11];

    // INTR_SET is write-only; its readback is always zero.
    assign sdp_done_set0      = 1'b0;
    assign sdp_done_set1      = 1'b0;
    assign cdp_done_set0      = 1'b0;
    assign cdp_done_set1      = 1'b0;
    assign pdp_done_set0      = 1'b0;
    assign pdp_done_set1      = 1'b0;
    assign cdma_dat_done_set0 = 1'b0;
    assign cdma_dat_done_set1 = 1'b0;
    assign cdma_wt_done_set0  = 1'b0;
    assign cdma_wt_done_set1  = 1'b0;
    assign cacc_done_set0     = 1'b0;
    assign cacc_done_set1     = 1'b0;

endmodule
